// File: rtl/clock_pkg.sv
// Shared definitions for the clock timekeeping stage: function numbers
// (state encoding shown on NUM), BCD field limits and the BCD increment helper.
package clock_pkg;

  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;
  localparam logic [1:0] MODE_SET_SEC  = 2'd3;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  typedef enum logic [1:0] {
    ST_RUN      = MODE_RUN,
    ST_SET_HOUR = MODE_SET_HOUR,
    ST_SET_MIN  = MODE_SET_MIN,
    ST_SET_SEC  = MODE_SET_SEC
  } state_t;

  // value: the BCD byte plus one (units 9 carries into tens), not yet limited.
  // wrap:  the input sits at the field limit, so the caller must load 00.
  typedef struct packed {
    logic       wrap;
    logic [7:0] value;
  } bcd_inc_t;

  function automatic bcd_inc_t bcd_inc(input logic [7:0] value, input logic [7:0] max);
    bcd_inc_t res;
    if (value[3:0] == 4'd9) begin
      res.value = {value[7:4] + 4'd1, 4'd0};
    end else begin
      res.value = {value[7:4], value[3:0] + 4'd1};
    end
    res.wrap = (value == max);
    return res;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Key input conditioner: two-flop synchroniser for an asynchronous, externally
// debounced key level, then a previous-value flop; pulse is one cycle per press.
module key_edge (
  input  logic CP,
  input  logic nCR,
  input  logic key,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // synchronise the key level and remember last cycle's synchronised value
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // rising edge only; releasing the key produces nothing
  assign pulse = sync2_r & ~prev_r;

endmodule

// File: rtl/clock_core.sv
// Timekeeping stage: BCD hh:mm:ss advanced once per CLK_DIV cycles of CP in RUN,
// with mode/inc keys to set each field. Optional hourly chime is built only
// when the macro CLOCK_CHIME_EN is defined; otherwise chime is tied low.
module clock_core
  import clock_pkg::*;
#(
  parameter int CLK_DIV = 1000
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic [1:0] NUM,
  output logic       tick,
  output logic       chime
);

  localparam int PRESC_W = $clog2(CLK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  state_t             state_r;
  logic [PRESC_W-1:0] prescale_r;
  logic [7:0]         hour_r;
  logic [7:0]         minute_r;
  logic [7:0]         second_r;

  logic     mode_edge_s;
  logic     inc_edge_s;
  logic     tick_s;
  bcd_inc_t hour_inc_s;
  bcd_inc_t min_inc_s;
  bcd_inc_t sec_inc_s;
  logic [7:0] hour_next_s;
  logic [7:0] min_next_s;
  logic [7:0] sec_next_s;
  logic [7:0] run_hour_s;
  logic [7:0] run_min_s;
  logic [7:0] run_sec_s;

  key_edge u_mode_edge (.CP(CP), .nCR(nCR), .key(key_mode), .pulse(mode_edge_s));
  key_edge u_inc_edge  (.CP(CP), .nCR(nCR), .key(key_inc),  .pulse(inc_edge_s));

  assign tick_s = (state_r == ST_RUN) && (prescale_r == PRESC_LAST);

  // per-field increment with wrap to 00 at the field limit
  assign hour_inc_s  = bcd_inc(hour_r,   HOUR_MAX);
  assign min_inc_s   = bcd_inc(minute_r, MINSEC_MAX);
  assign sec_inc_s   = bcd_inc(second_r, MINSEC_MAX);
  assign hour_next_s = hour_inc_s.wrap ? 8'h00 : hour_inc_s.value;
  assign min_next_s  = min_inc_s.wrap  ? 8'h00 : min_inc_s.value;
  assign sec_next_s  = sec_inc_s.wrap  ? 8'h00 : sec_inc_s.value;

  // time after one running second, carrying seconds -> minutes -> hours
  always_comb begin
    run_sec_s  = sec_next_s;
    run_min_s  = minute_r;
    run_hour_s = hour_r;
    if (sec_inc_s.wrap) begin
      run_min_s = min_next_s;
      if (min_inc_s.wrap) begin
        run_hour_s = hour_next_s;
      end else begin
        run_hour_s = hour_r;
      end
    end else begin
      run_min_s  = minute_r;
      run_hour_s = hour_r;
    end
  end

  // function state machine, prescaler and time registers
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_r    <= ST_RUN;
      prescale_r <= '0;
      hour_r     <= 8'h00;
      minute_r   <= 8'h00;
      second_r   <= 8'h00;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (tick_s) begin
            second_r <= run_sec_s;
            minute_r <= run_min_s;
            hour_r   <= run_hour_s;
          end
          if (mode_edge_s) begin
            state_r    <= ST_SET_HOUR;
            prescale_r <= '0;
          end else if (tick_s) begin
            prescale_r <= '0;
          end else begin
            prescale_r <= prescale_r + PRESC_ONE;
          end
        end
        ST_SET_HOUR: begin
          prescale_r <= '0;
          if (mode_edge_s) begin
            state_r <= ST_SET_MIN;
          end else if (inc_edge_s) begin
            hour_r <= hour_next_s;
          end
        end
        ST_SET_MIN: begin
          prescale_r <= '0;
          if (mode_edge_s) begin
            state_r <= ST_SET_SEC;
          end else if (inc_edge_s) begin
            minute_r <= min_next_s;
          end
        end
        ST_SET_SEC: begin
          prescale_r <= '0;
          if (mode_edge_s) begin
            state_r <= ST_RUN;
          end else if (inc_edge_s) begin
            second_r <= sec_next_s;
          end
        end
        default: begin
          state_r    <= ST_RUN;
          prescale_r <= '0;
        end
      endcase
    end
  end

`ifdef CLOCK_CHIME_EN
  logic chime_r;

  // chime high through xx:59:55..xx:59:59 while running, low in any SET state
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      chime_r <= 1'b0;
    end else if ((state_r != ST_RUN) || mode_edge_s) begin
      chime_r <= 1'b0;
    end else if (tick_s) begin
      chime_r <= (run_min_s == MINSEC_MAX) && (run_sec_s >= 8'h55);
    end else begin
      chime_r <= chime_r;
    end
  end

  assign chime = chime_r;
`else
  assign chime = 1'b0;
`endif

  assign hour   = hour_r;
  assign minute = minute_r;
  assign second = second_r;
  assign NUM    = state_r;
  assign tick   = tick_s;

endmodule

// File: tb/tb_clock_core.sv
// Directed self-checking bench for clock_core with CLK_DIV = 4.
module tb_clock_core;

  logic       CP = 1'b0;
  logic       nCR = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic [1:0] NUM;
  logic       tick;
  logic       chime;

  int checks = 0;
  int passes = 0;
  int tick_seen = 0;

  clock_core #(.CLK_DIV(4)) dut (
    .CP(CP), .nCR(nCR), .key_mode(key_mode), .key_inc(key_inc),
    .hour(hour), .minute(minute), .second(second), .NUM(NUM),
    .tick(tick), .chime(chime)
  );

  always #5 CP = ~CP;

  // Ends at a negedge with nCR released and keys low.
  task automatic apply_reset();
    @(negedge CP);
    nCR = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
    repeat (2) @(negedge CP);
    nCR = 1'b1;
  endtask

  // Caller is at a negedge. Hold keys 4 cycles, release for 3.
  task automatic press(input logic m, input logic i);
    key_mode = m; key_inc = i;
    repeat (4) begin @(negedge CP); if (tick) tick_seen = 1; end
    key_mode = 1'b0; key_inc = 1'b0;
    repeat (3) begin @(negedge CP); if (tick) tick_seen = 1; end
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) press(1'b0, 1'b1);
  endtask

  // Ends at the negedge right after the edge that enters RUN.
  task automatic mode_to_run();
    key_mode = 1'b1;
    repeat (3) @(negedge CP);
    key_mode = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CP);
    nCR = 1'b0;
    @(negedge CP);
    checks++; if (hour !== 8'h00) $display("FAIL rst_hour: got %h expected 00", hour); else passes++;
    checks++; if (minute !== 8'h00) $display("FAIL rst_minute: got %h expected 00", minute); else passes++;
    checks++; if (second !== 8'h00) $display("FAIL rst_second: got %h expected 00", second); else passes++;
    checks++; if (NUM !== 2'd0) $display("FAIL rst_num: got %0d expected 0", NUM); else passes++;
    checks++; if (tick !== 1'b0) $display("FAIL rst_tick: got %b expected 0", tick); else passes++;
    checks++; if (chime !== 1'b0) $display("FAIL rst_chime: got %b expected 0", chime); else passes++;
  endtask

  task automatic test_run();
    logic [7:0] exp_sec;
    nCR = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge CP);
        checks++;
        if (tick !== (c == 3)) $display("FAIL run_tick s=%0d c=%0d: got %b expected %b", s, c, tick, (c == 3));
        else passes++;
      end
      exp_sec = 8'((s / 10) * 16 + (s % 10));
      checks++; if (second !== exp_sec) $display("FAIL run_second: got %h expected %h", second, exp_sec); else passes++;
    end
    checks++; if (minute !== 8'h00) $display("FAIL run_minute: got %h expected 00", minute); else passes++;
  endtask

  task automatic test_set_hour();
    apply_reset();
    tick_seen = 0;
    key_mode = 1'b1;
    @(negedge CP);
    checks++; if (NUM !== 2'd0) $display("FAIL set_num_e1: got %0d expected 0", NUM); else passes++;
    @(negedge CP);
    checks++; if (NUM !== 2'd0) $display("FAIL set_num_e2: got %0d expected 0", NUM); else passes++;
    @(negedge CP);
    checks++; if (NUM !== 2'd1) $display("FAIL set_num_e3: got %0d expected 1", NUM); else passes++;
    key_mode = 1'b0;
    repeat (3) @(negedge CP);
    for (int n = 1; n <= 25; n++) begin
      press(1'b0, 1'b1);
      if (n == 10) begin
        checks++; if (hour !== 8'h10) $display("FAIL set_hour_10: got %h expected 10", hour); else passes++;
      end
      if (n == 24) begin
        checks++; if (hour !== 8'h00) $display("FAIL set_hour_wrap: got %h expected 00", hour); else passes++;
      end
    end
    checks++; if (hour !== 8'h01) $display("FAIL set_hour_25: got %h expected 01", hour); else passes++;
    checks++; if (minute !== 8'h00) $display("FAIL set_hour_min: got %h expected 00", minute); else passes++;
    checks++; if (second !== 8'h00) $display("FAIL set_hour_sec: got %h expected 00", second); else passes++;
    checks++; if (tick_seen !== 0) $display("FAIL set_hour_tick: got %0d expected 0", tick_seen); else passes++;
  endtask

  task automatic test_mode_cycle();
    apply_reset();
    press(1'b1, 1'b0);
    checks++; if (NUM !== 2'd1) $display("FAIL cyc_num1: got %0d expected 1", NUM); else passes++;
    press(1'b1, 1'b0);
    checks++; if (NUM !== 2'd2) $display("FAIL cyc_num2: got %0d expected 2", NUM); else passes++;
    press(1'b1, 1'b0);
    checks++; if (NUM !== 2'd3) $display("FAIL cyc_num3: got %0d expected 3", NUM); else passes++;
    mode_to_run();
    checks++; if (NUM !== 2'd0) $display("FAIL cyc_num0: got %0d expected 0", NUM); else passes++;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CP);
      checks++;
      if (tick !== (c == 3)) $display("FAIL cyc_tick c=%0d: got %b expected %b", c, tick, (c == 3));
      else passes++;
    end
    checks++; if (second !== 8'h01) $display("FAIL cyc_second: got %h expected 01", second); else passes++;
  endtask

  task automatic test_full_wrap();
    apply_reset();
    tick_seen = 0;
    press(1'b1, 1'b0); incs(23);
    press(1'b1, 1'b0); incs(59);
    press(1'b1, 1'b0); incs(58);
    checks++; if ({hour, minute, second} !== 24'h235958) $display("FAIL wrap_preset: got %h expected 235958", {hour, minute, second}); else passes++;
    checks++; if (tick_seen !== 0) $display("FAIL wrap_set_tick: got %0d expected 0", tick_seen); else passes++;
    mode_to_run();
    repeat (4) @(negedge CP);
    checks++; if ({hour, minute, second} !== 24'h235959) $display("FAIL wrap_59: got %h expected 235959", {hour, minute, second}); else passes++;
    repeat (4) @(negedge CP);
    checks++; if ({hour, minute, second} !== 24'h000000) $display("FAIL wrap_00: got %h expected 000000", {hour, minute, second}); else passes++;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    press(1'b1, 1'b0); press(1'b1, 1'b0);
    incs(3);
    checks++; if (minute !== 8'h03) $display("FAIL sim_pre_min: got %h expected 03", minute); else passes++;
    press(1'b1, 1'b1);
    checks++; if (NUM !== 2'd3) $display("FAIL sim_num: got %0d expected 3", NUM); else passes++;
    checks++; if (minute !== 8'h03) $display("FAIL sim_min: got %h expected 03", minute); else passes++;
    checks++; if (second !== 8'h00) $display("FAIL sim_sec: got %h expected 00", second); else passes++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    press(1'b1, 1'b0);
    incs(3);
    checks++; if (hour !== 8'h03) $display("FAIL mid_pre_hour: got %h expected 03", hour); else passes++;
    #2 nCR = 1'b0;
    #1;
    checks++; if (hour !== 8'h00) $display("FAIL mid_hour: got %h expected 00", hour); else passes++;
    checks++; if (NUM !== 2'd0) $display("FAIL mid_num: got %0d expected 0", NUM); else passes++;
    @(negedge CP);
    nCR = 1'b1;
  endtask

  task automatic test_chime();
    logic [7:0] exp_sec;
    logic       exp_chime;
    apply_reset();
    press(1'b1, 1'b0); press(1'b1, 1'b0); incs(59);
    press(1'b1, 1'b0); incs(50);
    checks++; if ({hour, minute, second} !== 24'h005950) $display("FAIL chime_preset: got %h expected 005950", {hour, minute, second}); else passes++;
    checks++; if (chime !== 1'b0) $display("FAIL chime_set: got %b expected 0", chime); else passes++;
    mode_to_run();
    for (int s = 51; s <= 60; s++) begin
      repeat (4) @(negedge CP);
      exp_sec = (s == 60) ? 8'h00 : 8'((s / 10) * 16 + (s % 10));
`ifdef CLOCK_CHIME_EN
      exp_chime = (s >= 55) && (s <= 59);
`else
      exp_chime = 1'b0;
`endif
      checks++; if (second !== exp_sec) $display("FAIL chime_sec: got %h expected %h", second, exp_sec); else passes++;
      checks++; if (chime !== exp_chime) $display("FAIL chime_s%0d: got %b expected %b", s, chime, exp_chime); else passes++;
    end
    checks++; if ({hour, minute} !== 16'h0100) $display("FAIL chime_hm: got %h expected 0100", {hour, minute}); else passes++;
  endtask

  initial begin
    test_reset();
    test_run();
    test_set_hour();
    test_mode_cycle();
    test_full_wrap();
    test_simultaneous();
    test_reset_mid();
    test_chime();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
